// File: rtl/fpnew_divsqrt_arbiter.sv
// Shares one multi-cycle divsqrt unit among NumReq requesters.
// Define FPNEW_DIVSQRT_ARB_RR_EN for round-robin, else fixed priority.
package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

module fpnew_divsqrt_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned WIDTH  = 64,
  localparam int unsigned IdxW  =
    ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NumReq-1:0]                 req_valid_i,
  output logic [NumReq-1:0]                 req_ready_o,
  input  logic [NumReq-1:0][1:0][WIDTH-1:0] req_operands_i,
  input  fpnew_pkg::operation_e             req_op_i [NumReq],
  input  fpnew_pkg::roundmode_e             req_rnd_mode_i [NumReq],
  input  fpnew_pkg::fp_format_e             req_dst_fmt_i [NumReq],
  output logic                              unit_in_valid_o,
  input  logic                              unit_in_ready_i,
  output logic [1:0][WIDTH-1:0]             unit_operands_o,
  output fpnew_pkg::operation_e             unit_op_o,
  output fpnew_pkg::roundmode_e             unit_rnd_mode_o,
  output fpnew_pkg::fp_format_e             unit_dst_fmt_o,
  output logic                              unit_flush_o,
  input  logic                              unit_out_valid_i,
  output logic                              unit_out_ready_o,
  input  logic [WIDTH-1:0]                  unit_result_i,
  input  fpnew_pkg::status_t                unit_status_i,
  output logic [NumReq-1:0]                 rsp_valid_o,
  input  logic [NumReq-1:0]                 rsp_ready_i,
  output logic [WIDTH-1:0]                  rsp_result_o,
  output fpnew_pkg::status_t                rsp_status_o,
  output logic [IdxW-1:0]                   owner_o,
  output logic                              busy_o
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT
  } state_e;

  typedef struct packed {
    logic [1:0][WIDTH-1:0] operands;
    operation_e            op;
    roundmode_e            rnd;
    fp_format_e            fmt;
  } issue_t;

  state_e          state_q, state_d;
  issue_t          issue_q, issue_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] prio;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_any;
  logic            grant;
  int unsigned     srch;

  // first valid requester at or after prio, wrapping at NumReq-1
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    srch    = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      srch = 32'(prio) + k;
      if (srch >= NumReq) srch = srch - NumReq;
      if (!gnt_any && req_valid_i[IdxW'(srch)]) begin
        gnt_any = 1'b1;
        gnt_idx = IdxW'(srch);
      end
    end
  end

  assign grant = (state_q == IDLE) && !flush_i && gnt_any;

`ifdef FPNEW_DIVSQRT_ARB_RR_EN
  logic [IdxW-1:0] prio_q, prio_d;

  assign prio = prio_q;

  always_comb begin
    prio_d = prio_q;
    if (grant) begin
      prio_d = (gnt_idx == IdxW'(NumReq - 1)) ?
               '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= '0;
    else         prio_q <= prio_d;
  end
`else
  assign prio = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      issue_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: if (unit_in_ready_i) state_d = WAIT;
      WAIT: begin
        if (unit_out_valid_i && rsp_ready_i[owner_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    issue_d = issue_q;
    owner_d = owner_q;
    if (grant) begin
      issue_d.operands = req_operands_i[gnt_idx];
      issue_d.op       = req_op_i[gnt_idx];
      issue_d.rnd      = req_rnd_mode_i[gnt_idx];
      issue_d.fmt      = req_dst_fmt_i[gnt_idx];
      owner_d          = gnt_idx;
    end
  end

  always_comb begin
    req_ready_o      = '0;
    unit_in_valid_o  = 1'b0;
    unit_out_ready_o = 1'b0;
    rsp_valid_o      = '0;
    if (grant) req_ready_o[gnt_idx] = 1'b1;
    unique case (state_q)
      ISSUE: unit_in_valid_o = !flush_i;
      WAIT: begin
        unit_out_ready_o     = rsp_ready_i[owner_q];
        rsp_valid_o[owner_q] = unit_out_valid_i && !flush_i;
      end
      default: ;
    endcase
  end

  assign unit_operands_o = issue_q.operands;
  assign unit_op_o       = issue_q.op;
  assign unit_rnd_mode_o = issue_q.rnd;
  assign unit_dst_fmt_o  = issue_q.fmt;
  assign unit_flush_o    = flush_i;
  assign rsp_result_o    = unit_result_i;
  assign rsp_status_o    = unit_status_i;
  assign owner_o         = owner_q;
  assign busy_o          = (state_q != IDLE);

endmodule
